// File: rtl/riscv_alu_pkg.sv
// Shared RV32 ALU definitions: control codes, flag indices, issue opcodes, issue FSM states.
package riscv_alu_pkg;

  localparam int ALU_XLEN = 32;

  typedef enum logic [2:0] {
    CTRL_ADD    = 3'd0,
    CTRL_SUB    = 3'd1,
    CTRL_AND    = 3'd2,
    CTRL_LSHIFT = 3'd3
  } aluCtrlE;

  localparam int FLAG_ZERO     = 0;
  localparam int FLAG_CARRY    = 1;
  localparam int FLAG_OVERFLOW = 2;
  localparam int FLAG_SIGN     = 3;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_SLL  = 4'd3,
    OP_BEQ  = 4'd8,
    OP_BNE  = 4'd9,
    OP_BLT  = 4'd10,
    OP_BGE  = 4'd11,
    OP_BLTU = 4'd12,
    OP_BGEU = 4'd13
  } opE;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } stateE;

  function automatic logic isBranchOp(input logic [3:0] op);
    return (op >= 4'd8) && (op <= 4'd13);
  endfunction

  function automatic logic isLegalOp(input logic [3:0] op);
    return (op <= 4'd3) || isBranchOp(op);
  endfunction

  // Branches compare by subtraction; illegal ops fall back to ADD.
  function automatic aluCtrlE ctrlFor(input logic [3:0] op);
    aluCtrlE c;
    c = CTRL_ADD;
    case (op)
      OP_SUB: c = CTRL_SUB;
      OP_AND: c = CTRL_AND;
      OP_SLL: c = CTRL_LSHIFT;
      default: if (isBranchOp(op)) c = CTRL_SUB;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Decode-side request and writeback-side result handshakes of the ALU issue unit.
interface alu_issue_unit_if;
  logic                                in_valid;
  logic                                in_ready;
  logic [3:0]                          in_op;
  logic [riscv_alu_pkg::ALU_XLEN-1:0]  in_a;
  logic [riscv_alu_pkg::ALU_XLEN-1:0]  in_b;
  logic [4:0]                          in_rd;
  logic                                out_valid;
  logic                                out_ready;
  logic [riscv_alu_pkg::ALU_XLEN-1:0]  out_result;
  logic [4:0]                          out_rd;
  logic                                out_is_branch;
  logic                                out_taken;
  logic                                out_err;

  modport master (
    output in_valid, in_op, in_a, in_b, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_is_branch, out_taken, out_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_is_branch, out_taken, out_err
  );
endinterface

// File: rtl/alu_issue_unit_branch_resolve.sv
// Branch condition from ALU flags of a - b; non-branch and illegal ops are never taken.
module branch_resolve
  import riscv_alu_pkg::*;
(
  input  logic [3:0] op,
  input  logic [3:0] flags,
  output logic       taken
);

  logic zero, carry, lessSigned;

  assign zero       = flags[FLAG_ZERO];
  assign carry      = flags[FLAG_CARRY];
  assign lessSigned = flags[FLAG_SIGN] ^ flags[FLAG_OVERFLOW];

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_BEQ:  taken = zero;
      OP_BNE:  taken = !zero;
      OP_BLT:  taken = lessSigned;
      OP_BGE:  taken = !lessSigned;
      OP_BLTU: taken = !carry;
      OP_BGEU: taken = carry;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue front end for the external combinational RV32 ALU: accept, execute one cycle, hold result.
//   state  | meaning
//   IDLE   | no op in flight, ready for a new one
//   EXEC   | registered op drives the ALU; result captured at cycle end
//   HOLD   | result presented until the consumer takes it
module alu_issue_unit
  import riscv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  alu_issue_unit_if.slave    bus,
  output logic [XLEN-1:0]    alu_a,
  output logic [XLEN-1:0]    alu_b,
  output logic [2:0]         alu_ctrl,
  input  logic [XLEN-1:0]    alu_result,
  input  logic [3:0]         alu_flag
);

  stateE           state, nextState;
  logic            load, capture;
  logic [3:0]      opReg;
  logic [XLEN-1:0] aReg, bReg;
  logic [4:0]      rdReg;
  logic [XLEN-1:0] resultReg;
  logic [4:0]      outRdReg;
  logic            branchReg, takenReg, errReg;
  logic            taken;

  branch_resolve uBranch (
    .op    (opReg),
    .flags (alu_flag),
    .taken (taken)
  );

  always_comb begin
    nextState    = state;
    load         = 1'b0;
    capture      = 1'b0;
    bus.in_ready = 1'b0;
    bus.out_valid = 1'b0;
    alu_a        = '0;
    alu_b        = '0;
    alu_ctrl     = CTRL_ADD;
    case (state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          load      = 1'b1;
          nextState = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_a     = aReg;
        alu_b     = (opReg == OP_SLL) ? {{(XLEN-5){1'b0}}, bReg[4:0]} : bReg;
        alu_ctrl  = ctrlFor(opReg);
        capture   = 1'b1;
        nextState = S_HOLD;
      end
      S_HOLD: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            load      = 1'b1;
            nextState = S_EXEC;
          end else begin
            nextState = S_IDLE;
          end
        end
      end
      default: nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      opReg     <= '0;
      aReg      <= '0;
      bReg      <= '0;
      rdReg     <= '0;
      resultReg <= '0;
      outRdReg  <= '0;
      branchReg <= 1'b0;
      takenReg  <= 1'b0;
      errReg    <= 1'b0;
    end else begin
      state <= nextState;
      if (load) begin
        opReg <= bus.in_op;
        aReg  <= bus.in_a;
        bReg  <= bus.in_b;
        rdReg <= bus.in_rd;
      end
      if (capture) begin
        resultReg <= isLegalOp(opReg) ? alu_result : '0;
        outRdReg  <= rdReg;
        branchReg <= isBranchOp(opReg);
        takenReg  <= taken;
        errReg    <= !isLegalOp(opReg);
      end
    end
  end

  assign bus.out_result    = resultReg;
  assign bus.out_rd        = outRdReg;
  assign bus.out_is_branch = branchReg;
  assign bus.out_taken     = takenReg;
  assign bus.out_err       = errReg;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit with a behavioural ALU beside it; results checked through a scoreboard.
module tb_alu_issue_unit;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [2:0]  ctrl;
    logic [31:0] res;
    logic        br;
    logic        tk;
    logic        err;
  } vecT;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        br;
    logic        tk;
    logic        err;
  } expT;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] aluA, aluB, aluResult;
  logic [2:0]  aluCtrl;
  logic [3:0]  aluFlag;

  int checks = 0;
  int errors = 0;
  expT expQ[$];

  alu_issue_unit_if bus ();

  alu_issue_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_a      (aluA),
    .alu_b      (aluB),
    .alu_ctrl   (aluCtrl),
    .alu_result (aluResult),
    .alu_flag   (aluFlag)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; carry on SUB is carry-out of a + ~b + 1.
  always_comb begin
    logic [32:0] wide;
    logic        v;
    wide = '0;
    v    = 1'b0;
    case (aluCtrl)
      3'd0: begin
        wide = {1'b0, aluA} + {1'b0, aluB};
        v    = (aluA[31] == aluB[31]) && (wide[31] != aluA[31]);
      end
      3'd1: begin
        wide = {1'b0, aluA} + {1'b0, ~aluB} + 33'd1;
        v    = (aluA[31] != aluB[31]) && (wide[31] != aluA[31]);
      end
      3'd2: wide = {1'b0, aluA & aluB};
      3'd3: wide = {1'b0, aluA << aluB[4:0]};
      default: wide = '0;
    endcase
    aluResult = wide[31:0];
    aluFlag   = {wide[31], v, wide[32], wide[31:0] == 32'd0};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Output-side monitor: pops on each transfer, checks stability while stalled.
  logic        held = 1'b0;
  logic [39:0] heldVal;
  always @(negedge clk) begin
    logic [39:0] cur;
    expT e;
    cur = {bus.out_result, bus.out_rd, bus.out_is_branch, bus.out_taken, bus.out_err};
    if (!rst && bus.out_valid) begin
      if (held) check("stall_stable", cur[31:0] ^ heldVal[31:0] | {24'd0, cur[39:32] ^ heldVal[39:32]}, 32'd0);
      held    = !bus.out_ready;
      heldVal = cur;
      if (bus.out_ready) begin
        if (expQ.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          check("out_result", bus.out_result, e.res);
          check("out_rd", {27'd0, bus.out_rd}, {27'd0, e.rd});
          check("out_is_branch", {31'd0, bus.out_is_branch}, {31'd0, e.br});
          check("out_taken", {31'd0, bus.out_taken}, {31'd0, e.tk});
          check("out_err", {31'd0, bus.out_err}, {31'd0, e.err});
        end
      end
    end else begin
      held = 1'b0;
    end
  end

  // Offers an op, waits (bounded) for acceptance, checks the EXEC cycle and latency.
  task automatic sendOp(input vecT v, output int waits);
    logic rdy, accepted;
    expT e;
    bus.in_valid = 1'b1;
    bus.in_op    = v.op;
    bus.in_a     = v.a;
    bus.in_b     = v.b;
    bus.in_rd    = v.rd;
    waits    = 0;
    accepted = 1'b0;
    while (!accepted && waits < 20) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) accepted = 1'b1;
      else     waits++;
    end
    #1 bus.in_valid = 1'b0;
    if (!accepted) begin
      check("accept_timeout", 32'd1, 32'd0);
      return;
    end
    e.res = v.res; e.rd = v.rd; e.br = v.br; e.tk = v.tk; e.err = v.err;
    expQ.push_back(e);
    @(negedge clk);
    check("exec_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("exec_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("exec_alu_ctrl", {29'd0, aluCtrl}, {29'd0, v.ctrl});
    if (!v.err) begin
      check("exec_alu_a", aluA, v.a);
      check("exec_alu_b", aluB, (v.op == 4'd3) ? {27'd0, v.b[4:0]} : v.b);
    end
    @(posedge clk);
    #1 check("latency_out_valid", {31'd0, bus.out_valid}, 32'd1);
  endtask

  vecT vecs[18];

  initial begin
    int w;
    vecT v;
    //          op     a             b             rd     ctrl  res           br    tk    err
    vecs[0]  = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 5'd5,  3'd0, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'd3,  32'h00000001, 32'h00000023, 5'd1,  3'd3, 32'h00000008, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{4'd10, 32'h80000000, 32'h00000001, 5'd2,  3'd1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{4'd12, 32'h80000000, 32'h00000001, 5'd3,  3'd1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{4'd13, 32'h80000000, 32'h00000001, 5'd4,  3'd1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{4'd8,  32'h00000007, 32'h00000007, 5'd6,  3'd1, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{4'd9,  32'h00000007, 32'h00000007, 5'd7,  3'd1, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{4'd11, 32'h80000000, 32'h00000001, 5'd8,  3'd1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{4'd2,  32'hF0F0FF00, 32'h0FF00FF0, 5'd9,  3'd2, 32'h00F00F00, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'd1,  32'h00000003, 32'h0000000A, 5'd10, 3'd1, 32'hFFFFFFF9, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{4'd5,  32'h00000005, 32'h00000006, 5'd11, 3'd0, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{4'd0,  32'h00000002, 32'h00000003, 5'd12, 3'd0, 32'h00000005, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{4'd15, 32'h00000001, 32'h00000001, 5'd13, 3'd0, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{4'd12, 32'h00000001, 32'h00000002, 5'd14, 3'd1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{4'd11, 32'h00000005, 32'h00000005, 5'd15, 3'd1, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{4'd9,  32'h00000001, 32'h00000002, 5'd16, 3'd1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{4'd10, 32'h00000001, 32'h00000002, 5'd17, 3'd1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{4'd11, 32'hFFFFFFFF, 32'h00000001, 5'd18, 3'd1, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_rd     = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_outs", {bus.out_rd, bus.out_is_branch, bus.out_taken, bus.out_err} | bus.out_result, 32'd0);
    check("rst_alu", aluA | aluB | {29'd0, aluCtrl}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Table: back-to-back with out_ready high, so every op after the first is accepted from HOLD.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      sendOp(vecs[i], w);
      if (i > 0) check("throughput_wait", w, 32'd0);
    end
    @(posedge clk);
    #1;

    // Backpressure on a SUB, then release together with a new op.
    bus.out_ready = 1'b0;
    v = '{4'd1, 32'd10, 32'd3, 5'd20, 3'd1, 32'd7, 1'b0, 1'b0, 1'b0};
    sendOp(v, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_out_result", bus.out_result, 32'd7);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    v = '{4'd0, 32'd2, 32'd3, 5'd21, 3'd0, 32'd5, 1'b0, 1'b0, 1'b0};
    sendOp(v, w);
    check("bp_release_accept", w, 32'd0);
    @(posedge clk);
    #1;

    // Reset while EXEC: op is dropped and never emitted.
    bus.in_valid = 1'b1;
    bus.in_op    = 4'd0;
    bus.in_a     = 32'd4;
    bus.in_b     = 32'd4;
    bus.in_rd    = 5'd9;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("pre_rst_exec_alu_a", aluA, 32'd4);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("post_rst_alu", aluA | aluB | {29'd0, aluCtrl}, 32'd0);
    check("post_rst_out_result", bus.out_result, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("scoreboard_empty", expQ.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
